// File: rtl/gen_sub_key_if.sv
// Bus bundle for one AES-128 key-expansion round: round constant, previous
// key and its qualifier in; next key and its strobe out.
interface gen_sub_key_if #(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
);
  logic [WORD_LEN-1:0] Rcon;
  logic [KEY_LEN-1:0]  data_in;
  logic                valid_in;
  logic [KEY_LEN-1:0]  data_out;
  logic                valid_out;

  modport master (
    output Rcon, data_in, valid_in,
    input  data_out, valid_out
  );

  modport slave (
    input  Rcon, data_in, valid_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/gen_sub_key.sv
// One AES-128 key-schedule round:
//   next = {n0..n3}, with temp = SubWord(RotWord(w3)) ^ Rcon.
// The result is registered, so latency is one clock and a new key can be
// accepted every cycle. There is no state other than the output register.

// Forward AES S-box for a single byte lane.
module gen_sub_key_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];
endmodule

module gen_sub_key #(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  gen_sub_key_if.slave  bus
);
  localparam int NUM_LANES = WORD_LEN / 8;
  localparam int STAGES    = 1;

  logic [WORD_LEN-1:0]            w_w0, w_w1, w_w2, w_w3;
  logic [NUM_LANES-1:0][7:0]      w_rot;
  logic [NUM_LANES-1:0][7:0]      w_sub;
  logic [WORD_LEN-1:0]            w_temp;
  logic [WORD_LEN-1:0]            w_n0, w_n1, w_n2, w_n3;
  logic [KEY_LEN-1:0]             w_next;
  logic [KEY_LEN-1:0]             r_data;
  logic [STAGES:1]                r_vld;
  logic [STAGES:0]                w_vld_pipe;

  // w0 is the most significant word of the key
  assign {w_w0, w_w1, w_w2, w_w3} = bus.data_in;

  // RotWord: left rotate w3 by one byte
  assign w_rot = {w_w3[WORD_LEN-9:0], w_w3[WORD_LEN-1:WORD_LEN-8]};

  // SubWord: one S-box per byte lane
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gen_sub_key_sbox u_sbox (
      .i_byte (w_rot[g]),
      .o_byte (w_sub[g])
    );
  end

  // Rcon is applied as supplied, no range check
  assign w_temp = w_sub ^ bus.Rcon;
  assign w_n0   = w_w0 ^ w_temp;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  // valid travels alongside the data as a shift register
  assign w_vld_pipe = {r_vld, bus.valid_in};

  // Capture the next key on valid input; otherwise hold the last key
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_vld  <= '0;
    end else begin
      r_vld <= w_vld_pipe[STAGES-1:0];
      if (bus.valid_in) r_data <= w_next;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = w_vld_pipe[STAGES];
endmodule

// File: tb/tb_gen_sub_key.sv
// Directed bench for gen_sub_key: FIPS-197 key-schedule vectors from a
// table plus hand-written reset, hold, back-to-back and async-reset cases.
module tb_gen_sub_key;
  logic clk;
  logic reset;

  gen_sub_key_if #(.KEY_LEN(128), .WORD_LEN(32)) bus ();

  gen_sub_key #(.KEY_LEN(128), .WORD_LEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [31:0]  rcon;
    logic [127:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"round1",  K0, 32'h01000000, K1};
    vecs[1] = '{"round2",  K1, 32'h02000000, K2};
    vecs[2] = '{"round3",  K2, 32'h04000000, 128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[3] = '{"round4",  128'h3d80477d4716fe3e1e237e446d7a883b, 32'h08000000,
                128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[4] = '{"round10", K9, 32'h36000000, K10};
    vecs[5] = '{"zero_key_rcon_ff", 128'h0, 32'hffffffff,
                128'h9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c};

    // Reset held with valid_in high: outputs stay clear across edges
    reset        = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = K0;
    bus.Rcon     = 32'h01000000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_data", bus.data_out, 128'h0);
      check("reset_valid", {127'h0, bus.valid_out}, 128'h0);
    end
    @(negedge clk);
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle_valid", {127'h0, bus.valid_out}, 128'h0);

    // Table vectors, applied on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      bus.data_in  = vecs[i].key;
      bus.Rcon     = vecs[i].rcon;
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
      check({vecs[i].name, "_data"}, bus.data_out, vecs[i].exp);
      check({vecs[i].name, "_valid"}, {127'h0, bus.valid_out}, 128'h1);
    end

    // Hold: drop valid and change data_in; key must not move
    bus.valid_in = 1'b0;
    bus.data_in  = K9;
    bus.Rcon     = 32'h36000000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {127'h0, bus.valid_out}, 128'h0);
      check("hold_data", bus.data_out, vecs[5].exp);
    end

    // Back-to-back rounds 1 and 2
    bus.data_in = K0; bus.Rcon = 32'h01000000; bus.valid_in = 1'b1;
    @(posedge clk); #1;
    check("b2b_r1_data", bus.data_out, K1);
    check("b2b_r1_valid", {127'h0, bus.valid_out}, 128'h1);
    bus.data_in = K1; bus.Rcon = 32'h02000000;
    @(posedge clk); #1;
    check("b2b_r2_data", bus.data_out, K2);
    check("b2b_r2_valid", {127'h0, bus.valid_out}, 128'h1);
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_valid", {127'h0, bus.valid_out}, 128'h0);
    check("b2b_end_data", bus.data_out, K2);

    // Async reset between edges discards an in-flight result
    bus.data_in = K9; bus.Rcon = 32'h36000000; bus.valid_in = 1'b1;
    @(posedge clk); #1;
    check("pre_async_data", bus.data_out, K10);
    #2 reset = 1'b0;
    #1;
    check("async_reset_data", bus.data_out, 128'h0);
    check("async_reset_valid", {127'h0, bus.valid_out}, 128'h0);
    @(posedge clk); #1;
    check("async_hold_data", bus.data_out, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    check("release_idle_valid", {127'h0, bus.valid_out}, 128'h0);
    check("release_idle_data", bus.data_out, 128'h0);
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset_data", bus.data_out, K10);
    check("first_after_reset_valid", {127'h0, bus.valid_out}, 128'h1);
    bus.valid_in = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
